// File: rtl/haze_pkg.sv
// Shared types and helpers for the haze-removal datapath.
package haze_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam logic [DEF_DATA_W-1:0] PIX_MAX = '1;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] r;
    logic [DEF_DATA_W-1:0] g;
    logic [DEF_DATA_W-1:0] b;
  } rgb_t;

  function automatic logic [DEF_DATA_W-1:0] min3(input rgb_t p);
    logic [DEF_DATA_W-1:0] m;
    m = (p.r < p.g) ? p.r : p.g;
    return (m < p.b) ? m : p.b;
  endfunction

endpackage

// File: rtl/min_cmp8.sv
// Combinational two-input unsigned minimum.
module min_cmp8 #(
  parameter int unsigned W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W-1:0] min_o
);

  always_comb begin
    min_o = (a_i < b_i) ? a_i : b_i;
  end

endmodule

// File: rtl/dark_channel_min.sv
// Two-stage streaming dark-channel extractor: RGB minimum, then trailing per-line window minimum.
// Optional frame maximum tracking of the output is enabled with DCM_MAXTRACK_EN.
module dark_channel_min
  import haze_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned WIN    = 3,
  parameter int unsigned LINE_W = 640
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sol,
  input  logic [DATA_W-1:0] in_r,
  input  logic [DATA_W-1:0] in_g,
  input  logic [DATA_W-1:0] in_b,
`ifdef DCM_MAXTRACK_EN
  input  logic              in_sof,
  output logic [DATA_W-1:0] dark_max,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_dark,
  output logic              out_sol,
  output logic              out_eol
);

  localparam int unsigned CntW = (LINE_W > 1) ? $clog2(LINE_W) : 1;
  localparam logic [CntW-1:0] ColLast = CntW'(LINE_W - 1);

  logic              en, accept;
  logic              s1_valid_q, s1_valid_d, s1_sol_q, s1_sol_d;
  logic [DATA_W-1:0] s1_min_q, s1_min_d;
  logic              out_valid_q, out_valid_d, out_sol_q, out_sol_d, out_eol_q, out_eol_d;
  logic [DATA_W-1:0] out_dark_q, out_dark_d;
  logic [CntW-1:0]   col_q, col_d;
  logic [DATA_W-1:0] rg_min, rgb_min, win_min;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = !rst && en;
  assign accept   = in_valid && in_ready;

  min_cmp8 #(.W(DATA_W)) u_min_rg  (.a_i(in_r),   .b_i(in_g), .min_o(rg_min));
  min_cmp8 #(.W(DATA_W)) u_min_rgb (.a_i(rg_min), .b_i(in_b), .min_o(rgb_min));

  if (WIN > 1) begin : g_hist
    logic [DATA_W-1:0] hist_q   [WIN-1];
    logic [DATA_W-1:0] hist_d   [WIN-1];
    logic [DATA_W-1:0] hist_eff [WIN-1];
    logic [DATA_W-1:0] chain    [WIN];

    // A line start masks the history so the window never reaches into the previous line.
    always_comb begin
      for (int unsigned i = 0; i < WIN - 1; i++) begin
        hist_eff[i] = s1_sol_q ? '1 : hist_q[i];
      end
    end

    assign chain[0] = s1_min_q;
    for (genvar i = 0; i < int'(WIN) - 1; i++) begin : g_tree
      min_cmp8 #(.W(DATA_W)) u_min_win (
        .a_i  (chain[i]),
        .b_i  (hist_eff[i]),
        .min_o(chain[i+1])
      );
    end
    assign win_min = chain[WIN-1];

    always_comb begin
      hist_d = hist_q;
      if (en && s1_valid_q) begin
        hist_d[0] = s1_min_q;
        for (int unsigned i = 1; i < WIN - 1; i++) begin
          hist_d[i] = hist_eff[i-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) hist_q <= '{default: '1};
      else     hist_q <= hist_d;
    end
  end else begin : g_nohist
    assign win_min = s1_min_q;
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sol_d    = s1_sol_q;
    s1_min_d    = s1_min_q;
    out_valid_d = out_valid_q;
    out_dark_d  = out_dark_q;
    out_sol_d   = out_sol_q;
    out_eol_d   = out_eol_q;
    col_d       = col_q;
    if (en) begin
      s1_valid_d  = accept;
      s1_sol_d    = in_sol;
      s1_min_d    = rgb_min;
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_dark_d = win_min;
        out_sol_d  = s1_sol_q;
        // Saturate on overlong lines so eol stays asserted until the next sol.
        if (s1_sol_q)              col_d = '0;
        else if (col_q != ColLast) col_d = col_q + 1'b1;
        out_eol_d = (col_d == ColLast);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sol_q    <= 1'b0;
      s1_min_q    <= '0;
      out_valid_q <= 1'b0;
      out_dark_q  <= '0;
      out_sol_q   <= 1'b0;
      out_eol_q   <= 1'b0;
      col_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sol_q    <= s1_sol_d;
      s1_min_q    <= s1_min_d;
      out_valid_q <= out_valid_d;
      out_dark_q  <= out_dark_d;
      out_sol_q   <= out_sol_d;
      out_eol_q   <= out_eol_d;
      col_q       <= col_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_dark  = out_dark_q;
  assign out_sol   = out_sol_q;
  assign out_eol   = out_eol_q;

`ifdef DCM_MAXTRACK_EN
  logic              s1_sof_q, s1_sof_d, out_sof_q, out_sof_d;
  logic [DATA_W-1:0] dark_max_q, dark_max_d;

  always_comb begin
    s1_sof_d   = s1_sof_q;
    out_sof_d  = out_sof_q;
    dark_max_d = dark_max_q;
    if (en) begin
      s1_sof_d = in_sof;
      if (s1_valid_q) out_sof_d = s1_sof_q;
    end
    // Frame start restarts the maximum from this pixel rather than folding it in.
    if (out_valid_q && out_ready) begin
      if (out_sof_q || (out_dark_q > dark_max_q)) dark_max_d = out_dark_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sof_q   <= 1'b0;
      out_sof_q  <= 1'b0;
      dark_max_q <= '0;
    end else begin
      s1_sof_q   <= s1_sof_d;
      out_sof_q  <= out_sof_d;
      dark_max_q <= dark_max_d;
    end
  end

  assign dark_max = dark_max_q;
`endif

endmodule

// File: tb/tb_dark_channel_min.sv
// Self-checking bench for dark_channel_min: directed literal cases plus randomized traffic
// checked against a per-line window model. Frame-max checks follow DCM_MAXTRACK_EN.
module tb_dark_channel_min;

  localparam int unsigned DW  = 8;
  localparam int unsigned WIN = 3;
  localparam int unsigned LW  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_sol;
  logic [DW-1:0] in_r, in_g, in_b;
  logic          out_valid, out_ready, out_sol, out_eol;
  logic [DW-1:0] out_dark;
`ifdef DCM_MAXTRACK_EN
  logic          in_sof;
  logic [DW-1:0] dark_max;
`endif

  always #5 clk = ~clk;

  dark_channel_min #(.DATA_W(DW), .WIN(WIN), .LINE_W(LW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_sol   (in_sol),
    .in_r     (in_r),
    .in_g     (in_g),
    .in_b     (in_b),
`ifdef DCM_MAXTRACK_EN
    .in_sof   (in_sof),
    .dark_max (dark_max),
`endif
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_dark (out_dark),
    .out_sol  (out_sol),
    .out_eol  (out_eol)
  );

  typedef struct {
    int dark;
    bit sol;
    bit eol;
    bit sof;
    int acc_cyc;
  } exp_t;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  exp_t exp_q[$];
  int   line_hist[$];
  int   col = 0;
  int   dm  = 0;
  int   got_dark[$];
  int   got_sol[$];
  int   got_eol[$];
  bit   chk_lat = 1'b0;
  bit   prev_stall = 1'b0;
  int   prev_dark, prev_sol, prev_eol;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Reference: dark value is the min over the last WIN pixel-minima of the current line.
  task automatic model_accept(input int r, input int g, input int b, input bit sol,
                              input bit sof);
    exp_t e;
    int   m;
    m = r;
    if (g < m) m = g;
    if (b < m) m = b;
    if (sol) begin
      line_hist.delete();
      col = 0;
    end else if (col < int'(LW) - 1) begin
      col++;
    end
    e.dark = m;
    foreach (line_hist[i]) if (line_hist[i] < e.dark) e.dark = line_hist[i];
    line_hist.push_front(m);
    if (line_hist.size() > int'(WIN) - 1) void'(line_hist.pop_back());
    e.sol     = sol;
    e.eol     = (col == int'(LW) - 1);
    e.sof     = sof;
    e.acc_cyc = cyc;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit   sof_now;
    if (rst) begin
      chk("in_ready_during_reset", in_ready, 0);
      exp_q.delete();
      line_hist.delete();
      col        = 0;
      dm         = 0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", out_valid, 1);
        chk("stall_dark_stable", out_dark, prev_dark);
        chk("stall_sol_stable", out_sol, prev_sol);
        chk("stall_eol_stable", out_eol, prev_eol);
      end
      if (out_valid && !out_ready) chk("in_ready_low_on_stall", in_ready, 0);
`ifdef DCM_MAXTRACK_EN
      chk("dark_max", dark_max, dm);
`endif
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output_beat", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("out_dark", out_dark, e.dark);
          chk("out_sol", out_sol, e.sol);
          chk("out_eol", out_eol, e.eol);
          if (chk_lat) chk("latency", cyc - e.acc_cyc, 2);
          if (e.sof || out_dark > dm) dm = out_dark;
        end
        got_dark.push_back(out_dark);
        got_sol.push_back(out_sol);
        got_eol.push_back(out_eol);
      end
      prev_stall = out_valid && !out_ready;
      prev_dark  = out_dark;
      prev_sol   = out_sol;
      prev_eol   = out_eol;
      if (in_valid && in_ready) begin
        sof_now = 1'b0;
`ifdef DCM_MAXTRACK_EN
        sof_now = in_sof;
`endif
        model_accept(in_r, in_g, in_b, in_sol, sof_now);
      end
    end
  end

  task automatic send(input bit sol, input int r, input int g, input int b, input bit sof);
    int t;
    t        = 0;
    in_valid = 1'b1;
    in_sol   = sol;
    in_r     = DW'(r);
    in_g     = DW'(g);
    in_b     = DW'(b);
`ifdef DCM_MAXTRACK_EN
    in_sof   = sof;
`endif
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sol   = 1'b0;
`ifdef DCM_MAXTRACK_EN
    in_sof   = 1'b0;
`endif
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_log(input string nm, input int dark[7], input int sol[7],
                           input int eol[7], input int n);
    chk({nm, "_count"}, got_dark.size(), n);
    for (int i = 0; i < n && i < got_dark.size(); i++) begin
      chk($sformatf("%s_dark%0d", nm, i), got_dark[i], dark[i]);
      chk($sformatf("%s_sol%0d", nm, i), got_sol[i], sol[i]);
      chk($sformatf("%s_eol%0d", nm, i), got_eol[i], eol[i]);
    end
    got_dark.delete();
    got_sol.delete();
    got_eol.delete();
  endtask

  task automatic line_a(input bit sof);
    send(1'b1, 200, 100, 150, sof);
    send(1'b0, 50, 60, 70, 1'b0);
    send(1'b0, 90, 80, 255, 1'b0);
    send(1'b0, 120, 130, 140, 1'b0);
    send(1'b0, 30, 200, 200, 1'b0);
  endtask

  initial begin
    int ref_dark[7];
    int ref_sol[7];
    int ref_eol[7];
    int n0;
    int t;
    ref_dark  = '{100, 50, 50, 50, 30, 10, 10};
    ref_sol   = '{1, 0, 0, 0, 0, 1, 0};
    ref_eol   = '{0, 0, 0, 1, 1, 0, 0};
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sol    = 1'b0;
    in_r      = '0;
    in_g      = '0;
    in_b      = '0;
    out_ready = 1'b1;
`ifdef DCM_MAXTRACK_EN
    in_sof    = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_dark", out_dark, 0);
    chk("reset_out_sol", out_sol, 0);
    chk("reset_out_eol", out_eol, 0);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Single line, line boundary and eol saturation, no backpressure.
    chk_lat = 1'b1;
    line_a(1'b1);
    send(1'b1, 255, 255, 10, 1'b0);
    send(1'b0, 255, 255, 255, 1'b0);
    idle(4);
    chk_lat = 1'b0;
    check_log("line", ref_dark, ref_sol, ref_eol, 7);
`ifdef DCM_MAXTRACK_EN
    chk("dark_max_frame", dark_max, 100);
    send(1'b1, 20, 20, 20, 1'b1);
    idle(4);
    chk("dark_max_new_frame", dark_max, 20);
    got_dark.delete();
    got_sol.delete();
    got_eol.delete();
`endif

    // Backpressure: downstream stalls for 4 cycles mid-line.
    fork
      line_a(1'b0);
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    idle(6);
    check_log("stall", ref_dark, ref_sol, ref_eol, 5);

    // Reset with beats in flight: nothing may emerge.
    send(1'b1, 40, 41, 42, 1'b0);
    send(1'b0, 43, 44, 45, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n0 = got_dark.size();
    idle(4);
    chk("no_output_after_reset", got_dark.size(), n0);
    send(1'b1, 9, 9, 9, 1'b0);
    idle(3);
    chk("post_reset_count", got_dark.size(), n0 + 1);
    if (got_dark.size() > 0) chk("post_reset_dark", got_dark[got_dark.size()-1], 9);

    // Randomized traffic with random backpressure.
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_sol    = ($urandom_range(0, 5) == 0);
      in_r      = DW'($urandom);
      in_g      = DW'($urandom);
      in_b      = DW'($urandom);
      if ($urandom_range(0, 3) == 0) in_b = DW'($urandom_range(0, 15));
`ifdef DCM_MAXTRACK_EN
      in_sof    = ($urandom_range(0, 40) == 0);
`endif
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("drain_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
